// File: rtl/ram8_access_ctrl.sv
// Request sequencer in front of the RAM8 bank: single-word read/write on a
// valid/ready handshake, read-latency wait with a one-cycle response, self-timed clear.
module ram8_access_ctrl #(
  parameter int DATA_WIDTH   = 16,
  parameter int ADDR_WIDTH   = 3,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  input  logic                  clear_start,
  output logic                  clear_busy,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic [DATA_WIDTH-1:0] ram_in,
  output logic                  ram_load,
  input  logic [DATA_WIDTH-1:0] ram_out
);

  localparam int LAT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(READ_LATENCY - 1);

  typedef enum logic [2:0] {
    IDLE, WRITE, READ, RESP, CLEAR, RECOVER
  } state_t;

  state_t                state_q, state_d;
  logic [LAT_W-1:0]      lat_q, lat_d;
  logic [ADDR_WIDTH-1:0] clr_q, clr_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] in_q, in_d;
  logic                  load_q, load_d;
  logic                  resp_valid_q, resp_valid_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  busy_q, busy_d;

  // Ready is combinational so a clear_start in IDLE blocks the same-cycle handshake.
  assign req_ready   = (state_q == IDLE) && !clear_start && !reset;
  assign resp_valid  = resp_valid_q;
  assign resp_rdata  = rdata_q;
  assign clear_busy  = busy_q;
  assign ram_address = addr_q;
  assign ram_in      = in_q;
  assign ram_load    = load_q;

  always_comb begin
    state_d      = state_q;
    lat_d        = lat_q;
    clr_d        = clr_q;
    addr_d       = addr_q;
    in_d         = in_q;
    load_d       = 1'b0;
    resp_valid_d = 1'b0;
    rdata_d      = rdata_q;
    busy_d       = busy_q;
    case (state_q)
      IDLE: begin
        addr_d = '0;
        in_d   = '0;
        if (clear_start) begin
          state_d = CLEAR;
          clr_d   = '0;
          load_d  = 1'b1;
          busy_d  = 1'b1;
        end else if (req_valid && req_ready) begin
          addr_d = req_addr;
          if (req_write) begin
            state_d = WRITE;
            in_d    = req_wdata;
            load_d  = 1'b1;
          end else begin
            state_d = READ;
            lat_d   = '0;
          end
        end
      end
      WRITE: begin
        state_d = RECOVER;
        addr_d  = '0;
        in_d    = '0;
      end
      READ: begin
        if (lat_q == LAT_LAST) begin
          state_d      = RESP;
          rdata_d      = ram_out;
          resp_valid_d = 1'b1;
          addr_d       = '0;
          lat_d        = '0;
        end else begin
          lat_d = lat_q + 1'b1;
        end
      end
      RESP: state_d = IDLE;
      CLEAR: begin
        if (clr_q == '1) begin
          state_d = RECOVER;
          clr_d   = '0;
          addr_d  = '0;
        end else begin
          clr_d  = clr_q + 1'b1;
          addr_d = clr_q + 1'b1;
          load_d = 1'b1;
        end
      end
      RECOVER: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      lat_q        <= '0;
      clr_q        <= '0;
      addr_q       <= '0;
      in_q         <= '0;
      load_q       <= 1'b0;
      resp_valid_q <= 1'b0;
      rdata_q      <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      lat_q        <= lat_d;
      clr_q        <= clr_d;
      addr_q       <= addr_d;
      in_q         <= in_d;
      load_q       <= load_d;
      resp_valid_q <= resp_valid_d;
      rdata_q      <= rdata_d;
      busy_q       <= busy_d;
    end
  end

endmodule
